// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the VRAM arbitration path.
//   VRAM_AW / VRAM_DW : VRAM address and data widths
//   owner_t           : tag carried down the access pipeline, naming the
//                       requester that owns the access in a stage
//   is_read_for()     : true when a pipeline stage holds a read owned by 'who'
// ---------------------------------------------------------------------------
package video_pkg;

   localparam int VRAM_AW = 16;
   localparam int VRAM_DW = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   function automatic logic is_read_for(input owner_t own, input logic rd, input owner_t who);
      return rd && (own == who);
   endfunction

endpackage

// File: rtl/vram_starve_ctr.sv
// ---------------------------------------------------------------------------
// vram_starve_ctr
// Counts consecutive cycles in which the CPU requests VRAM but is refused.
// The count saturates at MAX_WAIT and clears whenever the CPU is granted or
// drops its request. 'override' is high while the count sits at MAX_WAIT,
// telling the arbiter to serve the CPU regardless of vblank.
// Only instantiated when VRAM_STARVE_GUARD_EN is defined.
//   clk      : system clock
//   rst      : synchronous reset, active low
//   cpu_req  : CPU request
//   cpu_gnt  : CPU grant from the arbiter (same cycle)
//   override : CPU starvation limit reached
// ---------------------------------------------------------------------------
module vram_starve_ctr #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cpu_req,
   input  logic cpu_gnt,
   output logic override
);

   localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

   logic [3:0] cnt_r;

   // Saturating count of refused CPU request cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= 4'd0;
      end else if (cpu_req && !cpu_gnt) begin
         if (cnt_r != MAX_C) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         cnt_r <= 4'd0;
      end
   end

   assign override = (cnt_r == MAX_C);

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Single-port VRAM shared between a video fetcher and the CPU.
// Grants are combinational; one access is issued per cycle through a
// two-stage pipeline:
//   S1 : mem_addr / mem_we / mem_wdata registered with the winner's request
//   S2 : read data from mem_rdata is captured for the owner of the access,
//        giving rvalid two cycles after the grant.
// The external memory is expected to drive mem_rdata for the presented
// mem_addr during the S1 cycle; it is captured at the end of that cycle.
// Priority: CPU first while vblank=1, video first otherwise.
// Optional build macro VRAM_STARVE_GUARD_EN adds a starvation counter that
// forces a CPU grant after MAX_WAIT refused cycles (MAX_WAIT 1..15).
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   vblank                       : vertical blank (CPU priority when high)
//   vid_req/vid_addr/vid_gnt     : video request handshake
//   vid_rdata/vid_rvalid         : video read return
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata/cpu_gnt            : CPU request handshake
//   cpu_rdata/cpu_rvalid         : CPU read return (reads only)
//   mem_addr/mem_we/mem_wdata    : registered VRAM command
//   mem_rdata                    : VRAM read data
// ---------------------------------------------------------------------------
module vram_arbiter
   import video_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vblank,
   input  logic               vid_req,
   input  logic [VRAM_AW-1:0] vid_addr,
   output logic               vid_gnt,
   output logic [VRAM_DW-1:0] vid_rdata,
   output logic               vid_rvalid,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [VRAM_AW-1:0] cpu_addr,
   input  logic [VRAM_DW-1:0] cpu_wdata,
   output logic               cpu_gnt,
   output logic [VRAM_DW-1:0] cpu_rdata,
   output logic               cpu_rvalid,
   output logic [VRAM_AW-1:0] mem_addr,
   output logic               mem_we,
   output logic [VRAM_DW-1:0] mem_wdata,
   input  logic [VRAM_DW-1:0] mem_rdata
);

   logic               override_s;
   logic               vid_gnt_s;
   logic               cpu_gnt_s;
   owner_t             win_s;

   owner_t             s1_own_r;
   logic [VRAM_AW-1:0] mem_addr_r;
   logic               mem_we_r;
   logic [VRAM_DW-1:0] mem_wdata_r;

   owner_t             s2_own_r;
   logic               s2_rd_r;
   logic [VRAM_DW-1:0] vid_rdata_r;
   logic [VRAM_DW-1:0] cpu_rdata_r;

`ifdef VRAM_STARVE_GUARD_EN
   vram_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .cpu_req  (cpu_req),
      .cpu_gnt  (cpu_gnt_s),
      .override (override_s)
   );
`else
   assign override_s = 1'b0;
`endif

   // Arbitration: pick this cycle's winner; nothing is granted during reset.
   always_comb begin
      vid_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
      win_s     = OWN_NONE;
      if (!rst) begin
         win_s = OWN_NONE;
      end else if (cpu_req && (vblank || !vid_req || override_s)) begin
         cpu_gnt_s = 1'b1;
         win_s     = OWN_CPU;
      end else if (vid_req) begin
         vid_gnt_s = 1'b1;
         win_s     = OWN_VID;
      end else begin
         win_s = OWN_NONE;
      end
   end

   // Stage 1: register the winner's command; idle cycles keep the address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_own_r    <= OWN_NONE;
         mem_addr_r  <= {VRAM_AW{1'b0}};
         mem_we_r    <= 1'b0;
         mem_wdata_r <= {VRAM_DW{1'b0}};
      end else begin
         s1_own_r <= win_s;
         case (win_s)
            OWN_CPU: begin
               mem_addr_r  <= cpu_addr;
               mem_we_r    <= cpu_we;
               mem_wdata_r <= cpu_wdata;
            end
            OWN_VID: begin
               mem_addr_r  <= vid_addr;
               mem_we_r    <= 1'b0;
               mem_wdata_r <= mem_wdata_r;
            end
            default: begin
               mem_addr_r  <= mem_addr_r;
               mem_we_r    <= 1'b0;
               mem_wdata_r <= mem_wdata_r;
            end
         endcase
      end
   end

   // Stage 2: advance the owner tag and capture read data for its owner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_own_r    <= OWN_NONE;
         s2_rd_r     <= 1'b0;
         vid_rdata_r <= {VRAM_DW{1'b0}};
         cpu_rdata_r <= {VRAM_DW{1'b0}};
      end else begin
         s2_own_r <= s1_own_r;
         s2_rd_r  <= (s1_own_r != OWN_NONE) && !mem_we_r;
         if (is_read_for(s1_own_r, !mem_we_r, OWN_VID)) begin
            vid_rdata_r <= mem_rdata;
         end else begin
            vid_rdata_r <= vid_rdata_r;
         end
         if (is_read_for(s1_own_r, !mem_we_r, OWN_CPU)) begin
            cpu_rdata_r <= mem_rdata;
         end else begin
            cpu_rdata_r <= cpu_rdata_r;
         end
      end
   end

   assign vid_gnt    = vid_gnt_s;
   assign cpu_gnt    = cpu_gnt_s;
   assign mem_addr   = mem_addr_r;
   assign mem_we     = mem_we_r;
   assign mem_wdata  = mem_wdata_r;
   assign vid_rdata  = vid_rdata_r;
   assign cpu_rdata  = cpu_rdata_r;
   // rvalid is a pure decode of the S2 registers, so it is glitch-free.
   assign vid_rvalid = is_read_for(s2_own_r, s2_rd_r, OWN_VID);
   assign cpu_rvalid = is_read_for(s2_own_r, s2_rd_r, OWN_CPU);

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Self-checking bench for vram_arbiter. A reference model decides each
// cycle's winner from the priority rules, predicts grants, keeps a shadow
// copy of VRAM and queues the expected bus command and read returns. A
// separate monitor pops and compares those whenever the DUT presents them.
// Build with VRAM_STARVE_GUARD_EN defined to exercise the starvation guard.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;
   import video_pkg::*;

   localparam int unsigned MAX_WAIT = 4;
`ifdef VRAM_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, vblank, vid_req, cpu_req, cpu_we;
   logic [15:0] vid_addr, cpu_addr, mem_addr;
   logic [7:0]  cpu_wdata, mem_wdata, mem_rdata, vid_rdata, cpu_rdata;
   logic        vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, mem_we;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_on = 1'b0;

   logic [7:0] vram   [0:65535];
   logic [7:0] shadow [0:65535];

   typedef struct {
      int         due;
      logic [7:0] data;
   } rd_exp_t;

   typedef struct {
      int          due;
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      bit          rst_hit;
   } bus_exp_t;

   rd_exp_t  vid_q[$];
   rd_exp_t  cpu_q[$];
   bus_exp_t bus_q[$];

   vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .vblank     (vblank),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_gnt    (vid_gnt),
      .vid_rdata  (vid_rdata),
      .vid_rvalid (vid_rvalid),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // VRAM device: asynchronous read of the presented address, write at edge.
   assign mem_rdata = vram[mem_addr];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: priority rules, waiting count, shadow memory.
   int          wait_cnt = 0;
   logic [15:0] hold_addr = 16'h0000;
   always @(negedge clk) begin
      bit exp_v, exp_c, ovr;
      exp_v = 1'b0;
      exp_c = 1'b0;
      if (model_on) begin
         if (!rst) begin
            // Accesses whose return falls after this reset edge are lost.
            while (vid_q.size() > 0 && vid_q[$].due > cyc) void'(vid_q.pop_back());
            while (cpu_q.size() > 0 && cpu_q[$].due > cyc) void'(cpu_q.pop_back());
            wait_cnt  = 0;
            hold_addr = 16'h0000;
            bus_q.push_back(bus_exp_t'{cyc + 1, 16'h0000, 1'b0, 8'h00, 1'b1});
         end else begin
            ovr   = GUARD && (wait_cnt >= int'(MAX_WAIT));
            exp_c = cpu_req && (vblank || !vid_req || ovr);
            exp_v = vid_req && !exp_c;
            if (exp_c) begin
               hold_addr = cpu_addr;
               if (cpu_we) shadow[cpu_addr] = cpu_wdata;
               else cpu_q.push_back(rd_exp_t'{cyc + 2, shadow[cpu_addr]});
               bus_q.push_back(bus_exp_t'{cyc + 1, cpu_addr, cpu_we, cpu_wdata, 1'b0});
            end else if (exp_v) begin
               hold_addr = vid_addr;
               vid_q.push_back(rd_exp_t'{cyc + 2, shadow[vid_addr]});
               bus_q.push_back(bus_exp_t'{cyc + 1, vid_addr, 1'b0, 8'h00, 1'b0});
            end else begin
               bus_q.push_back(bus_exp_t'{cyc + 1, hold_addr, 1'b0, 8'h00, 1'b0});
            end
            if (cpu_req && !exp_c) wait_cnt = (wait_cnt < int'(MAX_WAIT)) ? wait_cnt + 1 : wait_cnt;
            else wait_cnt = 0;
         end
         check("vid_gnt", {31'd0, vid_gnt}, {31'd0, exp_v});
         check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, exp_c});
      end
   end

   // Monitor: compares bus command and read returns against queued expectations.
   logic [7:0] last_vid = 8'h00;
   logic [7:0] last_cpu = 8'h00;
   bit         synced = 1'b0;
   always @(negedge clk) begin
      rd_exp_t  re;
      bus_exp_t be;
      if (model_on) begin
         if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
            be = bus_q.pop_front();
            if (be.rst_hit) begin
               last_vid = 8'h00;
               last_cpu = 8'h00;
               synced   = 1'b1;
               check("reset mem_wdata", {24'd0, mem_wdata}, 32'h0);
            end
            check("mem_addr", {16'd0, mem_addr}, {16'd0, be.addr});
            check("mem_we", {31'd0, mem_we}, {31'd0, be.we});
            if (be.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, be.wdata});
         end
         if (synced) begin
            if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
               re = vid_q.pop_front();
               check("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
               check("vid_rdata", {24'd0, vid_rdata}, {24'd0, re.data});
               last_vid = re.data;
            end else begin
               check("vid_rvalid idle", {31'd0, vid_rvalid}, 32'd0);
               check("vid_rdata hold", {24'd0, vid_rdata}, {24'd0, last_vid});
            end
            if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
               re = cpu_q.pop_front();
               check("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
               check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, re.data});
               last_cpu = re.data;
            end else begin
               check("cpu_rvalid idle", {31'd0, cpu_rvalid}, 32'd0);
               check("cpu_rdata hold", {24'd0, cpu_rdata}, {24'd0, last_cpu});
            end
         end
      end
   end

   initial begin
      bit vdone, cdone, got;
      int n;
      rst = 1'b0; vblank = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      vid_addr = 16'h0000; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      for (int i = 0; i < 65536; i++) begin
         vram[i]   = 8'($urandom);
         shadow[i] = vram[i];
      end
      model_on = 1'b1;
      repeat (3) step();
      rst = 1'b1;

      // Video stream, addresses 0x4000..0x4003 on consecutive cycles.
      for (int i = 0; i < 4; i++) begin
         vid_req  = 1'b1;
         vid_addr = 16'h4000 + 16'(i);
         #2;
         check("t37 vid_gnt", {31'd0, vid_gnt}, 32'd1);
         if (i > 0) check("t37 mem_addr", {16'd0, mem_addr}, 32'h4000 + 32'(i - 1));
         step();
      end
      vid_req = 1'b0;
      repeat (3) step();

      // vblank: CPU write wins over video, video follows.
      vblank = 1'b1; vid_req = 1'b1; vid_addr = 16'h4010;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4400; cpu_wdata = 8'h5A;
      #2;
      check("t38 cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      check("t38 vid_gnt held", {31'd0, vid_gnt}, 32'd0);
      step();
      cpu_req = 1'b0;
      #2;
      check("t38 vid_gnt", {31'd0, vid_gnt}, 32'd1);
      check("t38 mem_we", {31'd0, mem_we}, 32'd1);
      check("t38 mem_addr", {16'd0, mem_addr}, 32'h4400);
      check("t38 mem_wdata", {24'd0, mem_wdata}, 32'h5A);
      step();
      vid_req = 1'b0;
      #2;
      check("t38 no cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      step();
      vblank = 1'b0;
      repeat (2) step();

      // Continuous video traffic with a waiting CPU read.
      vid_req = 1'b1; vid_addr = 16'h4020;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4800;
      got = 1'b0; n = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         #2;
         if (cpu_gnt) begin
            got = 1'b1;
            n = k;
         end
         step();
      end
`ifdef VRAM_STARVE_GUARD_EN
      check("t39 cpu_gnt cycle", 32'(n), 32'(MAX_WAIT + 1));
      cpu_req = 1'b0;
      step();
      #2;
      check("t39 cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      vid_req = 1'b0;
      step();
`else
      check("t39 no cpu_gnt", {31'd0, got}, 32'd0);
      vid_req = 1'b0;
      #2;
      check("t39 cpu_gnt after vid", {31'd0, cpu_gnt}, 32'd1);
      step();
      cpu_req = 1'b0;
`endif
      repeat (3) step();

      // Reset one cycle after a video grant discards that access.
      vid_req = 1'b1; vid_addr = 16'h4001;
      #2;
      check("t40 vid_gnt", {31'd0, vid_gnt}, 32'd1);
      step();
      rst = 1'b0;
      #2;
      check("t40 gnt in reset", {31'd0, vid_gnt}, 32'd0);
      step();
      rst = 1'b1;
      #2;
      check("t40 mem_addr", {16'd0, mem_addr}, 32'h0);
      check("t40 mem_we", {31'd0, mem_we}, 32'd0);
      check("t40 vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
      check("t40 vid_rdata", {24'd0, vid_rdata}, 32'h0);
      check("t40 first gnt", {31'd0, vid_gnt}, 32'd1);
      step();
      vid_req = 1'b0;
      repeat (3) step();

      // Random traffic, vblank toggling and occasional reset.
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         vdone = vid_req && vid_gnt;
         cdone = cpu_req && cpu_gnt;
         @(posedge clk);
         #1;
         if (!vid_req || vdone) begin
            vid_req  = ($urandom_range(0, 3) != 0);
            vid_addr = 16'h4000 + 16'($urandom_range(0, 15));
         end
         if (!cpu_req || cdone) begin
            cpu_req   = ($urandom_range(0, 2) == 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'h4000 + 16'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) vblank = ~vblank;
         rst = ($urandom_range(0, 299) != 0);
      end

      vid_req = 1'b0; cpu_req = 1'b0; rst = 1'b1;
      repeat (6) step();
      check("vid_q drained", 32'(vid_q.size()), 32'd0);
      check("cpu_q drained", 32'(cpu_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
